// File: rtl/l2_bus_arbiter.sv
// Shares the single L1->L2 request port between the I-cache and the D-cache.
// One transaction outstanding at a time: arbitrate, issue, wait for completion, ack.
module l2_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  input  logic              dc_req,
  input  logic [1:0]        dc_op,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_ack,
  output logic              l2_valid,
  output logic [1:0]        l2_op,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_ready,
  input  logic              l2_done,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  ic_grants,
  output logic [CNT_W-1:0]  dc_grants
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    ACK   = 2'b11
  } state_t;

  localparam logic [31:0]      TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  state_t      state_r;
  state_t      state_next_s;
  logic        last_owner_r;
  logic [31:0] wait_cnt_r;
  logic        grant_s;
  logic        winner_s;
  logic        timeout_hit_s;

  // next-state, arbitration and timeout detection
  always_comb begin
    state_next_s  = state_r;
    grant_s       = 1'b0;
    winner_s      = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (ic_req || dc_req) begin
          grant_s      = 1'b1;
          state_next_s = ISSUE;
          if (MODE != 0) begin
            winner_s = dc_req;
          end else if (ic_req && dc_req) begin
            winner_s = ~last_owner_r;
          end else begin
            winner_s = dc_req;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (l2_ready) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = ISSUE;
        end
      end
      WAIT: begin
        // completion beats a timeout landing on the same cycle
        if (l2_done) begin
          state_next_s = ACK;
        end else if ((TIMEOUT_C != 32'd0) && ((wait_cnt_r + 32'd1) >= TIMEOUT_C)) begin
          timeout_hit_s = 1'b1;
          state_next_s  = ACK;
        end else begin
          state_next_s = WAIT;
        end
      end
      ACK: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // state, registered outputs, grant bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= IDLE;
      last_owner_r <= 1'b1;
      wait_cnt_r   <= 32'd0;
      l2_valid     <= 1'b0;
      l2_op        <= 2'b00;
      l2_addr      <= '0;
      ic_ack       <= 1'b0;
      dc_ack       <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b0;
      timeout_err  <= 1'b0;
      ic_grants    <= '0;
      dc_grants    <= '0;
    end else begin
      state_r  <= state_next_s;
      l2_valid <= (state_next_s == ISSUE);
      busy     <= (state_next_s != IDLE);
      ic_ack   <= (state_next_s == ACK) && !owner;
      dc_ack   <= (state_next_s == ACK) && owner;

      if (state_r == WAIT) begin
        wait_cnt_r <= wait_cnt_r + 32'd1;
      end else begin
        wait_cnt_r <= 32'd0;
      end

      if (timeout_hit_s) begin
        timeout_err <= 1'b1;
      end

      if (state_r == ACK) begin
        last_owner_r <= owner;
      end

      if (grant_s) begin
        owner <= winner_s;
        if (winner_s) begin
          l2_addr <= dc_addr;
          l2_op   <= (dc_op == 2'b11) ? 2'b00 : dc_op;
          if (dc_grants != CNT_MAX_C) begin
            dc_grants <= dc_grants + CNT_ONE_C;
          end
        end else begin
          l2_addr <= ic_addr;
          l2_op   <= 2'b00;
          if (ic_grants != CNT_MAX_C) begin
            ic_grants <= ic_grants + CNT_ONE_C;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with shared stimulus and
// checks both against a transaction-level model of the arbitration rules.
module tb_l2_bus_arbiter;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ic_req, dc_req, l2_ready, l2_done;
  logic [31:0] ic_addr, dc_addr;
  logic [1:0]  dc_op;

  logic        rr_ic_ack, rr_dc_ack, rr_l2_valid, rr_busy, rr_owner, rr_timeout_err;
  logic [1:0]  rr_l2_op;
  logic [31:0] rr_l2_addr;
  logic [15:0] rr_ic_grants, rr_dc_grants;
  logic        fp_ic_ack, fp_dc_ack, fp_l2_valid, fp_busy, fp_owner, fp_timeout_err;
  logic [1:0]  fp_l2_op;
  logic [31:0] fp_l2_addr;
  logic [2:0]  fp_ic_grants, fp_dc_grants;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          last_rr;
  bit          win_rr, win_fp, te;
  int          cnt_rr_i, cnt_rr_d, cnt_fp_i, cnt_fp_d;
  logic [31:0] exp_addr_rr, exp_addr_fp;
  logic [1:0]  exp_op_rr, exp_op_fp;

  always #5 clock = ~clock;

  l2_bus_arbiter #(.ADDR_W(32), .MODE(0), .TIMEOUT(TO), .CNT_W(16)) u_rr (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(rr_ic_ack),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_ack(rr_dc_ack),
    .l2_valid(rr_l2_valid), .l2_op(rr_l2_op), .l2_addr(rr_l2_addr),
    .l2_ready(l2_ready), .l2_done(l2_done),
    .busy(rr_busy), .owner(rr_owner), .timeout_err(rr_timeout_err),
    .ic_grants(rr_ic_grants), .dc_grants(rr_dc_grants)
  );

  l2_bus_arbiter #(.ADDR_W(32), .MODE(1), .TIMEOUT(TO), .CNT_W(3)) u_fp (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(fp_ic_ack),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_ack(fp_dc_ack),
    .l2_valid(fp_l2_valid), .l2_op(fp_l2_op), .l2_addr(fp_l2_addr),
    .l2_ready(l2_ready), .l2_done(l2_done),
    .busy(fp_busy), .owner(fp_owner), .timeout_err(fp_timeout_err),
    .ic_grants(fp_ic_grants), .dc_grants(fp_dc_grants)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat(input int c, input int mx);
    return (c < mx) ? c + 1 : c;
  endfunction

  function automatic logic [1:0] eff_op(input logic [1:0] op);
    return (op == 2'b11) ? 2'b00 : op;
  endfunction

  task automatic model_reset();
    last_rr = 1'b1; te = 1'b0;
    cnt_rr_i = 0; cnt_rr_d = 0; cnt_fp_i = 0; cnt_fp_d = 0;
    exp_addr_rr = 32'd0; exp_addr_fp = 32'd0;
    exp_op_rr = 2'b00; exp_op_fp = 2'b00;
  endtask

  task automatic check_all(input string ph, input bit valid, input bit bsy, input bit ack);
    check({ph, ".rr_valid"}, 32'(rr_l2_valid), 32'(valid));
    check({ph, ".fp_valid"}, 32'(fp_l2_valid), 32'(valid));
    check({ph, ".rr_busy"}, 32'(rr_busy), 32'(bsy));
    check({ph, ".fp_busy"}, 32'(fp_busy), 32'(bsy));
    check({ph, ".rr_ic_ack"}, 32'(rr_ic_ack), 32'(ack && !win_rr));
    check({ph, ".rr_dc_ack"}, 32'(rr_dc_ack), 32'(ack && win_rr));
    check({ph, ".fp_ic_ack"}, 32'(fp_ic_ack), 32'(ack && !win_fp));
    check({ph, ".fp_dc_ack"}, 32'(fp_dc_ack), 32'(ack && win_fp));
    check({ph, ".rr_terr"}, 32'(rr_timeout_err), 32'(te));
    check({ph, ".fp_terr"}, 32'(fp_timeout_err), 32'(te));
    check({ph, ".rr_ic_gr"}, 32'(rr_ic_grants), 32'(cnt_rr_i));
    check({ph, ".rr_dc_gr"}, 32'(rr_dc_grants), 32'(cnt_rr_d));
    check({ph, ".fp_ic_gr"}, 32'(fp_ic_grants), 32'(cnt_fp_i));
    check({ph, ".fp_dc_gr"}, 32'(fp_dc_grants), 32'(cnt_fp_d));
    check({ph, ".rr_addr"}, rr_l2_addr, exp_addr_rr);
    check({ph, ".fp_addr"}, fp_l2_addr, exp_addr_fp);
    check({ph, ".rr_op"}, 32'(rr_l2_op), 32'(exp_op_rr));
    check({ph, ".fp_op"}, 32'(fp_l2_op), 32'(exp_op_fp));
    if (bsy) begin
      check({ph, ".rr_owner"}, 32'(rr_owner), 32'(win_rr));
      check({ph, ".fp_owner"}, 32'(fp_owner), 32'(win_fp));
    end
  endtask

  // One transaction starting in an IDLE cycle. r = cycles ready is held low,
  // k = WAIT cycle on which done arrives (k > TO means it never arrives),
  // rst_w = WAIT cycle on which reset is asserted (0 = never).
  task automatic run_txn(input bit iq, input bit dq, input logic [31:0] ia,
                         input logic [31:0] da, input logic [1:0] op,
                         input int r, input int k, input int rst_w);
    int end_w;
    ic_req = iq; dc_req = dq; ic_addr = ia; dc_addr = da; dc_op = op;
    l2_ready = 1'($urandom); l2_done = 1'($urandom);
    if (!iq && !dq) begin
      tick();
      check_all("idle", 1'b0, 1'b0, 1'b0);
      return;
    end
    win_rr = (iq && dq) ? !last_rr : dq;
    win_fp = dq;
    if (win_rr) cnt_rr_d = sat(cnt_rr_d, 65535); else cnt_rr_i = sat(cnt_rr_i, 65535);
    if (win_fp) cnt_fp_d = sat(cnt_fp_d, 7);     else cnt_fp_i = sat(cnt_fp_i, 7);
    exp_addr_rr = win_rr ? da : ia;
    exp_op_rr   = win_rr ? eff_op(op) : 2'b00;
    exp_addr_fp = win_fp ? da : ia;
    exp_op_fp   = win_fp ? eff_op(op) : 2'b00;
    tick();
    check_all("issue", 1'b1, 1'b1, 1'b0);
    // request-side changes while busy must not disturb the transaction
    ic_addr = $urandom; dc_addr = $urandom; dc_op = 2'($urandom);
    for (int i = 0; i < r; i++) begin
      l2_ready = 1'b0; l2_done = 1'($urandom);
      tick();
      check_all("issue_hold", 1'b1, 1'b1, 1'b0);
    end
    l2_ready = 1'b1; l2_done = 1'($urandom);
    tick();
    end_w = (k <= TO) ? k : TO;
    for (int w = 1; w <= end_w; w++) begin
      check_all("wait", 1'b0, 1'b1, 1'b0);
      l2_ready = 1'($urandom);
      if (w == rst_w) begin
        reset = 1'b1; l2_done = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
        tick();
        reset = 1'b0; l2_done = 1'b0;
        model_reset();
        check_all("rst_mid", 1'b0, 1'b0, 1'b0);
        check("rst_mid.rr_owner", 32'(rr_owner), 32'd0);
        tick();
        check_all("rst_after", 1'b0, 1'b0, 1'b0);
        return;
      end
      l2_done = (w == k);
      tick();
    end
    if (k > TO) te = 1'b1;
    last_rr = win_rr;
    check_all("ack", 1'b0, 1'b1, 1'b1);
    ic_req = 1'b0; dc_req = 1'b0;
    l2_done = 1'($urandom); l2_ready = 1'($urandom);
    tick();
    check_all("post_ack", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; ic_addr = 32'd0; dc_addr = 32'd0;
    dc_op = 2'b00; l2_ready = 1'b0; l2_done = 1'b0;
    win_rr = 1'b0; win_fp = 1'b0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    check_all("reset", 1'b0, 1'b0, 1'b0);
    check("reset.rr_owner", 32'(rr_owner), 32'd0);
    check("reset.fp_owner", 32'(fp_owner), 32'd0);

    // both request every transaction: RR alternates I,D,I,D; FP gives D each time
    for (int i = 0; i < 4; i++)
      run_txn(1'b1, 1'b1, 32'h0000_2000 + 32'(i * 64), 32'h0000_3000 + 32'(i * 64), 2'b00, 0, 1, 0);
    check("alt.rr_ic_grants", 32'(rr_ic_grants), 32'd2);
    check("alt.rr_dc_grants", 32'(rr_dc_grants), 32'd2);
    check("alt.fp_ic_grants", 32'(fp_ic_grants), 32'd0);
    check("alt.fp_dc_grants", 32'(fp_dc_grants), 32'd4);

    // I-only with immediate ready/done
    run_txn(1'b1, 1'b0, 32'h0000_1040, 32'h0, 2'b00, 0, 1, 0);
    // writeback with ready held low 5 cycles
    run_txn(1'b0, 1'b1, 32'h0, 32'hDEAD_BEC0, 2'b01, 5, 2, 0);
    // done exactly on the timeout cycle: no error
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_5000, 2'b10, 1, TO, 0);
    check("done_at_to.terr", 32'(rr_timeout_err), 32'd0);
    // done never arrives: forced completion and sticky error
    run_txn(1'b0, 1'b1, 32'h0, 32'h0000_6000, 2'b00, 0, TO + 4, 0);
    check("timeout.terr", 32'(rr_timeout_err), 32'd1);
    run_txn(1'b1, 1'b0, 32'h0000_7000, 32'h0, 2'b00, 0, 2, 0);
    check("sticky.terr", 32'(fp_timeout_err), 32'd1);

    // randomized traffic, including reserved op and idle cycles
    for (int i = 0; i < 60; i++)
      run_txn(1'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(1, TO + 3)), 0);

    // reset in the middle of WAIT, then first simultaneous request goes to I
    run_txn(1'b1, 1'b1, 32'h0000_8000, 32'h0000_9000, 2'b10, 1, TO + 2, 3);
    run_txn(1'b1, 1'b1, 32'h0000_A000, 32'h0000_B000, 2'b01, 0, 1, 0);
    check("post_rst.rr_ic_grants", 32'(rr_ic_grants), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
